instr_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode constants, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Opcode lives in the top nibble of every instruction word.
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM and realigns returned data with its PC.
// Latency: first instruction 2 cycles after reset release, then 1/cycle; branch target issues 3 edges after redirect.
// Backpressure: stall holds every output; a branch overrides stall; HALT freezes fetch until reset.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int                        ADDR_W      = cpu_pkg::ADDR_W,
  parameter int                        INSTR_W     = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]         RESET_PC    = '0,
  parameter logic [3:0]                HALT_OPCODE = cpu_pkg::OP_HALT
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic [ADDR_W-1:0]   iram_addr,
  input  logic [INSTR_W-1:0]  iram_q,
  input  logic                stall,
  input  logic                branch_valid,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  output logic                halted
);

  import cpu_pkg::*;

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;

  logic [ADDR_W-1:0]    r_fetch_pc,    w_fetch_pc_nxt;
  logic [ADDR_W-1:0]    r_pend_pc,     w_pend_pc_nxt;
  logic                 r_pend_valid,  w_pend_valid_nxt;
  logic [INSTR_W-1:0]   r_instr,       w_instr_nxt;
  logic [ADDR_W-1:0]   r_instr_pc,    w_instr_pc_nxt;
  logic                 r_instr_valid, w_instr_valid_nxt;
  logic                 r_halted,      w_halted_nxt;

  // The ROM keeps reading fetch_pc while stalled, which is one address
  // ahead of the pending word. The pending word is therefore captured on
  // the first stalled edge and replayed from here on release.
  logic [INSTR_W-1:0]   r_hold_dat,    w_hold_dat_nxt;
  logic                 r_hold_vld,    w_hold_vld_nxt;

  logic [INSTR_W-1:0]   w_pend_dat;
  logic                 w_pend_is_halt;

  assign w_pend_dat     = r_hold_vld ? r_hold_dat : iram_q;
  assign w_pend_is_halt = r_pend_valid && (opcode_of(w_pend_dat) == HALT_OPCODE);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-register values for the fetch pipeline.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_pend_pc_nxt     = r_pend_pc;
    w_pend_valid_nxt  = r_pend_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_halted_nxt      = r_halted;
    w_hold_dat_nxt    = r_hold_dat;
    w_hold_vld_nxt    = r_hold_vld;

    case (r_state)
      RUN: begin
        if (branch_valid) begin
          // Redirect squashes both the in-flight ROM read and the word that
          // would have issued on this edge.
          w_fetch_pc_nxt    = branch_target;
          w_pend_valid_nxt  = 1'b0;
          w_instr_valid_nxt = 1'b0;
          w_hold_vld_nxt    = 1'b0;
        end else if (stall) begin
          if (!r_hold_vld && r_pend_valid) begin
            w_hold_dat_nxt = iram_q;
            w_hold_vld_nxt = 1'b1;
          end
        end else begin
          w_pend_pc_nxt     = r_fetch_pc;
          w_pend_valid_nxt  = 1'b1;
          w_fetch_pc_nxt    = r_fetch_pc + 1'b1;
          w_instr_nxt       = w_pend_dat;
          w_instr_pc_nxt    = r_pend_pc;
          w_instr_valid_nxt = r_pend_valid;
          w_hold_vld_nxt    = 1'b0;
          // The HALT word itself still issues on this edge.
          if (w_pend_is_halt) begin
            w_state_nxt  = HALT;
            w_halted_nxt = 1'b1;
          end
        end
      end
      HALT: begin
        w_instr_valid_nxt = 1'b0;
        w_halted_nxt      = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Pipeline registers: PC, pending ROM slot, issue slot and stall capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_pend_pc     <= '0;
      r_pend_valid  <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_hold_dat    <= '0;
      r_hold_vld    <= 1'b0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_pend_pc     <= w_pend_pc_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_hold_dat    <= w_hold_dat_nxt;
      r_hold_vld    <= w_hold_vld_nxt;
    end
  end

  assign iram_addr   = r_fetch_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus, scoreboard queue, decoupled issue monitor.
// Latency: ROM model has a registered 1-cycle read.
// Backpressure: stall/branch driven on the falling edge.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic [7:0]  iram_addr;
  logic [15:0] iram_q;
  logic        stall;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom [256];
  logic [23:0] sb_q [$];

  instr_fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .iram_addr     (iram_addr),
    .iram_q        (iram_q),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered-read ROM model.
  initial iram_q = 16'h0000;
  always @(posedge clock) iram_q <= rom[iram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] pc, input logic [15:0] word);
    sb_q.push_back({pc, word});
  endtask

  task automatic wait_issue(input logic [7:0] pc, input int max_cycles);
    bit found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (instr_valid && instr_pc == pc) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_issue pc=%0h not issued within %0d cycles", pc, max_cycles);
    end
  endtask

  // Monitor: an issue happens on every edge that was not a plain stall.
  initial begin
    logic st, br, rn;
    logic [23:0] e;
    forever begin
      @(posedge clock);
      st = stall;
      br = branch_valid;
      rn = reset_n;
      #1;
      if (rn && reset_n && instr_valid && !(st && !br)) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue unexpected pc=%0h instr=%0h", instr_pc, instr);
        end else begin
          e = sb_q.pop_front();
          if ({instr_pc, instr} !== e) begin
            n_fail++;
            $display("FAIL issue actual pc=%0h instr=%0h expected pc=%0h instr=%0h",
                     instr_pc, instr, e[23:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0]   = 16'hC0FF;
    rom[1]   = 16'h3102;
    rom[2]   = 16'h9A00;
    rom[100] = 16'hF000;

    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 8'h00;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_addr",   32'(iram_addr),   32'h0);
    check("rst_valid",  32'(instr_valid), 32'h0);
    check("rst_instr",  32'(instr),       32'h0);
    check("rst_pc",     32'(instr_pc),    32'h0);
    check("rst_halted", 32'(halted),      32'h0);

    // Stream from reset
    push(8'd0, 16'hC0FF);
    push(8'd1, 16'h3102);
    push(8'd2, 16'h9A00);
    push(8'd3, 16'h1003);
    reset_n = 1'b1;
    @(negedge clock);
    check("lat_e1_valid", 32'(instr_valid), 32'h0);
    @(negedge clock);
    check("lat_e2_valid", 32'(instr_valid), 32'h1);
    check("lat_e2_instr", 32'(instr),       32'hC0FF);
    check("lat_e2_pc",    32'(instr_pc),    32'h0);

    // Stall hold while 3102 is presented
    wait_issue(8'd1, 4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_instr", 32'(instr),       32'h3102);
      check("stall_pc",    32'(instr_pc),    32'h1);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_addr",  32'(iram_addr),   32'h3);
    end
    stall = 1'b0;
    @(negedge clock);
    check("release_pc",    32'(instr_pc), 32'h2);
    check("release_instr", 32'(instr),    32'h9A00);

    // Branch to 5 while pc 3 is presented; pc 4 is squashed
    wait_issue(8'd3, 4);
    push(8'd5, 16'h1005);
    push(8'd6, 16'h1006);
    branch_valid  = 1'b1;
    branch_target = 8'h05;
    @(negedge clock);
    branch_valid = 1'b0;
    check("br_e1_valid", 32'(instr_valid), 32'h0);
    check("br_e1_addr",  32'(iram_addr),   32'h05);
    @(negedge clock);
    check("br_e2_valid", 32'(instr_valid), 32'h0);
    @(negedge clock);
    check("br_e3_valid", 32'(instr_valid), 32'h1);
    check("br_e3_pc",    32'(instr_pc),    32'h05);
    check("br_e3_instr", 32'(instr),       32'h1005);

    // Branch overriding stall, target 0x24
    @(negedge clock);
    for (int k = 36; k < 100; k++) push(8'(k), 16'h1000 + 16'(k));
    push(8'd100, 16'hF000);
    stall         = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 8'h24;
    @(negedge clock);
    stall        = 1'b0;
    branch_valid = 1'b0;
    check("brst_e1_valid", 32'(instr_valid), 32'h0);
    check("brst_e1_addr",  32'(iram_addr),   32'h24);
    @(negedge clock);
    check("brst_e2_valid", 32'(instr_valid), 32'h0);
    @(negedge clock);
    check("brst_e3_valid", 32'(instr_valid), 32'h1);
    check("brst_e3_pc",    32'(instr_pc),    32'h24);

    // Sequential run into HALT at pc 100
    wait_issue(8'd100, 80);
    check("halt_issue_valid",  32'(instr_valid), 32'h1);
    check("halt_issue_instr",  32'(instr),       32'hF000);
    check("halt_issue_halted", 32'(halted),      32'h1);
    check("halt_issue_addr",   32'(iram_addr),   32'd102);
    @(negedge clock);
    check("halt_next_valid",  32'(instr_valid), 32'h0);
    check("halt_next_halted", 32'(halted),      32'h1);
    branch_valid  = 1'b1;
    branch_target = 8'h10;
    stall         = 1'b1;
    @(negedge clock);
    check("halt_br_addr",   32'(iram_addr),   32'd102);
    check("halt_br_valid",  32'(instr_valid), 32'h0);
    check("halt_br_halted", 32'(halted),      32'h1);
    branch_valid = 1'b0;
    stall        = 1'b0;
    @(negedge clock);
    check("halt_hold_valid", 32'(instr_valid), 32'h0);

    // Asynchronous reset clears halted between edges
    #2 reset_n = 1'b0;
    #1;
    check("arst_halted", 32'(halted),      32'h0);
    check("arst_valid",  32'(instr_valid), 32'h0);
    check("arst_addr",   32'(iram_addr),   32'h0);

    // Wrap: redirect to 0xFE right after reset release
    push(8'hFE, 16'h10FE);
    push(8'hFF, 16'h10FF);
    push(8'h00, 16'hC0FF);
    push(8'h01, 16'h3102);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("wrap_e1_valid", 32'(instr_valid), 32'h0);
    branch_valid  = 1'b1;
    branch_target = 8'hFE;
    @(negedge clock);
    branch_valid = 1'b0;
    check("wrap_br_valid", 32'(instr_valid), 32'h0);
    check("wrap_br_addr",  32'(iram_addr),   32'hFE);
    wait_issue(8'hFE, 4);
    wait_issue(8'h01, 6);
    reset_n = 1'b0;

    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
